// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request/response handshake.
// A fixed number of wait states separates request acceptance from the response.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    // state  | meaning
    // IDLE   | ready for a request
    // WAIT   | request captured, counting wait states
    // RESP   | response registered and presented until rsp_ready
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic        acc_write;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic        acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0] merged;

    assign req_ready  = (state == S_IDLE);
    assign rsp_valid  = (state == S_RESP);
    assign accept     = req_valid && (state == S_IDLE);
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (cnt == 4'd0));

    // With zero wait states the array is accessed on the acceptance edge itself,
    // so the live request inputs stand in for the captured copy.
    always_comb begin
        acc_write = cap_write;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        acc_wstrb = cap_wstrb;
        if (state == S_IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end
    end

    assign acc_err = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign acc_idx = acc_addr[AW+1:2];

    always_comb begin
        merged = mem[acc_idx];
        for (int i = 0; i < 4; i++) begin
            if (acc_wstrb[i]) merged[8*i +: 8] = acc_wdata[8*i +: 8];
        end
    end

    // Storage is not reset; rst_n gating drops a store whose RESP entry coincides with reset.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && acc_write && !acc_err) mem[acc_idx] <= merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            cap_write <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_wstrb <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cap_write <= req_write;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_wstrb <= req_wstrb;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                S_RESP: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
        end
    end
endmodule
